bram_32k_initiator: RTL

//  Bus initiator driving the split BRAM read (AR/R) and write (AW/W/B) responder channels from a simple CPU-side request port.

---
 rtl/bram_32k_initiator.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bram_32k_initiator.sv
// bram_32k_initiator: CPU req/rsp port to split AR/R + AW/W/B BRAM responder.
// Optional watchdog enabled by defining BRAM_INIT_TIMEOUT_EN.
module bram_32k_initiator #(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  arvalid,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic [31:0]           rdata,
  output logic                  rready,
  output logic                  awvalid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awready,
  output logic                  wvalid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_now;
  logic                  w_now;
  logic                  busy;
  logic                  tmo;
  logic                  unused;

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign aw_now = aw_done | awready;
  assign w_now  = w_done | wready;
  assign busy   = (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                  (state == S_WR) || (state == S_WR_RESP);

`ifdef BRAM_INIT_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CW-1:0] tmo_cnt;
  logic          fin;

  assign fin = (state == S_RD_ADDR && arready && rvalid) ||
               (state == S_RD_DATA && rvalid) ||
               (state == S_WR && aw_now && w_now && bvalid) ||
               (state == S_WR_RESP && bvalid);

  always_ff @(posedge clk) begin
    if (rst || !busy) tmo_cnt <= '0;
    else              tmo_cnt <= tmo_cnt + 1'b1;
  end

  // a completing handshake wins over a watchdog hit in the same cycle
  assign tmo    = busy && !fin &&
                  (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign unused = ^req_addr[1:0];
`else
  assign tmo    = 1'b0;
  assign unused = ^{req_addr[1:0], TIMEOUT_CYCLES, busy};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      addr_q    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr_q    <= req_addr[ADDR_WIDTH+1:2];
            wdata     <= req_wdata;
            wstrb     <= req_wstrb;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (req_we) begin
              state   <= S_WR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              bready  <= 1'b1;
            end else begin
              state   <= S_RD_ADDR;
              arvalid <= 1'b1;
              rready  <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            if (rvalid) begin
              rsp_rdata <= rdata;
              rready    <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              state <= S_RD_DATA;
            end
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rsp_rdata <= rdata;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_WR: begin
          if (awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_now && w_now) begin
            if (bvalid) begin
              bready    <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              state <= S_WR_RESP;
            end
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (tmo) begin
        arvalid   <= 1'b0;
        rready    <= 1'b0;
        awvalid   <= 1'b0;
        wvalid    <= 1'b0;
        bready    <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= 1'b1;
        state     <= S_RESP;
      end
    end
  end

endmodule
